// File: rtl/mux_select_arbiter_pkg.sv
// Shared definitions for the two-requester byte arbiter: datapath width
// and the grant FSM state encoding.
package mux_select_arbiter_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

endpackage : mux_select_arbiter_pkg

// File: rtl/mux_select_arbiter_if.sv
// Bundle of the two requester handshakes plus the valid/ready output stage.
// The slave modport is the arbiter side; the master modport drives requests
// and consumes the output byte.
interface mux_select_arbiter_if;
   import mux_select_arbiter_pkg::*;

   logic              req0;
   logic [DATA_W-1:0] data0;
   logic              ack0;
   logic              req1;
   logic [DATA_W-1:0] data1;
   logic              ack1;
   logic              mux_sel;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport slave (
      input  req0, data0, req1, data1, out_ready,
      output ack0, ack1, mux_sel, out_valid, out_data
   );

   modport master (
      output req0, data0, req1, data1, out_ready,
      input  ack0, ack1, mux_sel, out_valid, out_data
   );

endinterface : mux_select_arbiter_if

// File: rtl/mux_select_arbiter_mux.sv
// Shared 8-bit 2:1 datapath mux: sel=0 passes in0, sel=1 passes in1.
module mux_select_arbiter_mux
   import mux_select_arbiter_pkg::*;
(
   input  logic              sel,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] dout
);

   assign dout = sel ? in1 : in0;

endmodule : mux_select_arbiter_mux

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter granting the shared byte mux to one of two requesters
// at a time. Each grant is bounded to MAX_BURST beats; accepted bytes land
// in a single-entry valid/ready output register.
module mux_select_arbiter
   import mux_select_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   mux_select_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   state_t            state, state_nx;
   logic              last, last_nx;       // requester served by the most recent grant
   logic [CNT_W-1:0]  cnt, cnt_nx;         // beats taken in the current grant
   logic              mux_sel, mux_sel_nx;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] mux_out;
   logic              accept;
   logic              ack0, ack1;

   // Datapath select follows the registered grant.
   mux_select_arbiter_mux u_mux (
      .sel  (mux_sel),
      .in0  (bus.data0),
      .in1  (bus.data1),
      .dout (mux_out)
   );

   // The output register can take a byte when empty or being drained now.
   assign accept = !out_valid || bus.out_ready;

   // Grant FSM next-state, handshake acks and burst bookkeeping.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_nx   = state;
      last_nx    = last;
      cnt_nx     = cnt;
      mux_sel_nx = mux_sel;
      ack0       = 1'b0;
      ack1       = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.req0 && !bus.req1)      state_nx = GNT0;
            else if (bus.req1 && !bus.req0) state_nx = GNT1;
            else if (bus.req0 && bus.req1)  state_nx = last ? GNT0 : GNT1;
         end
         GNT0: begin
            ack0 = bus.req0 && accept;
            if (ack0) cnt_nx = cnt + 1'b1;
            if ((ack0 && cnt == CNT_LAST) || !bus.req0) begin
               last_nx  = 1'b0;
               cnt_nx   = '0;
               state_nx = bus.req1 ? GNT1 : (bus.req0 ? GNT0 : IDLE);
            end
         end
         GNT1: begin
            ack1 = bus.req1 && accept;
            if (ack1) cnt_nx = cnt + 1'b1;
            if ((ack1 && cnt == CNT_LAST) || !bus.req1) begin
               last_nx  = 1'b1;
               cnt_nx   = '0;
               state_nx = bus.req0 ? GNT0 : (bus.req1 ? GNT1 : IDLE);
            end
         end
         default: state_nx = IDLE;
      endcase

      // Select tracks the grant; IDLE keeps whatever was last selected.
      if (state_nx == GNT0)      mux_sel_nx = 1'b0;
      else if (state_nx == GNT1) mux_sel_nx = 1'b1;
   end

   // Grant state, round-robin pointer, burst counter and select register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= 1'b1;
         cnt     <= '0;
         mux_sel <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all
         // registers update from the same pre-edge values.
         state   <= state_nx;
         last    <= last_nx;
         cnt     <= cnt_nx;
         mux_sel <= mux_sel_nx;
      end
   end

   // Single-entry output stage: push on ack, pop on ready, both at once keeps it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         // NOTE: the data register is reset too, so a consumer never sees
         // an undefined byte after reset even though valid gates it.
         out_data  <= '0;
      end else if (ack0 || ack1) begin
         out_valid <= 1'b1;
         out_data  <= mux_out;
      end else if (bus.out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.ack0      = ack0;
   assign bus.ack1      = ack1;
   assign bus.mux_sel   = mux_sel;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;

endmodule : mux_select_arbiter

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for the round-robin byte arbiter: reset, single request,
// burst alternation, backpressure, early release, tie-breaking, and a
// MAX_BURST=1 instance for strict alternation.
module tb_mux_select_arbiter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mux_select_arbiter_if bus ();
   mux_select_arbiter_if bus_b1 ();

   mux_select_arbiter #(.MAX_BURST(4), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   mux_select_arbiter #(.MAX_BURST(1), .CNT_W(1)) dut_b1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b1.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Step to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] prev_byte;
      logic       g1;

      rst_n         = 1'b0;
      bus.req0      = 1'b0;
      bus.req1      = 1'b0;
      bus.data0     = 8'h00;
      bus.data1     = 8'h00;
      bus.out_ready = 1'b0;
      bus_b1.req0      = 1'b0;
      bus_b1.req1      = 1'b0;
      bus_b1.data0     = 8'h00;
      bus_b1.data1     = 8'h00;
      bus_b1.out_ready = 1'b0;
      prev_byte = 8'h00;

      // Reset values
      #12;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_mux_sel",   bus.mux_sel,   0);
      check("rst_out_data",  bus.out_data,  8'h00);
      check("rst_ack0",      bus.ack0,      0);
      check("rst_ack1",      bus.ack1,      0);
      tick();
      rst_n = 1'b1;

      // Single requester: grant next cycle, byte valid the cycle after
      bus.req0 = 1'b1; bus.data0 = 8'hA5; bus.out_ready = 1'b1;
      settle();
      check("single_idle_ack0", bus.ack0, 0);
      tick();
      check("single_mux_sel",   bus.mux_sel,   0);
      check("single_ack0",      bus.ack0,      1);
      check("single_valid_pre", bus.out_valid, 0);
      tick();
      bus.req0 = 1'b0;
      settle();
      check("single_out_valid", bus.out_valid, 1);
      check("single_out_data",  bus.out_data,  8'hA5);
      check("single_ack0_drop", bus.ack0,      0);
      tick();
      check("single_drained",   bus.out_valid, 0);

      // Fresh reset, then a tie: req0 wins first, 4+4 bursts with no bubble
      rst_n = 1'b0;
      settle();
      rst_n = 1'b1;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.data0 = 8'h10; bus.data1 = 8'h20;
      settle();
      check("tie_idle_noack", bus.ack0 | bus.ack1, 0);
      for (int c = 0; c < 8; c++) begin
         tick();
         bus.data0 = 8'(8'h10 + c);
         bus.data1 = 8'(8'h20 + c);
         settle();
         g1 = (c >= 4);
         check($sformatf("burst_ack0_c%0d", c),    bus.ack0,    !g1);
         check($sformatf("burst_ack1_c%0d", c),    bus.ack1,    g1);
         check($sformatf("burst_mux_sel_c%0d", c), bus.mux_sel, g1);
         if (c > 0) check($sformatf("burst_data_c%0d", c), bus.out_data, prev_byte);
         prev_byte = g1 ? 8'(8'h20 + c) : 8'(8'h10 + c);
      end
      tick();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      settle();
      check("burst_last_data",  bus.out_data, 8'h27);
      check("burst_back_gnt0",  bus.mux_sel,  0);
      check("burst_drop_ack0",  bus.ack0,     0);
      tick();

      // Second tie after serving req0: req1 wins
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data1 = 8'h55;
      settle();
      check("tie2_idle_noack", bus.ack0 | bus.ack1, 0);
      tick();
      check("tie2_mux_sel", bus.mux_sel, 1);
      check("tie2_ack1",    bus.ack1,    1);
      check("tie2_ack0",    bus.ack0,    0);
      tick();
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      settle();
      check("tie2_data", bus.out_data, 8'h55);
      tick();

      // Backpressure: stalled beats do not count toward the burst
      bus.req0 = 1'b1; bus.data0 = 8'h31; bus.out_ready = 1'b0;
      tick();
      bus.req1 = 1'b1;
      settle();
      check("bp_first_ack0", bus.ack0, 1);
      check("bp_first_ack1", bus.ack1, 0);
      tick();
      bus.data0 = 8'h32;
      settle();
      check("bp_stall_ack0",  bus.ack0,      0);
      check("bp_stall_valid", bus.out_valid, 1);
      for (int s = 0; s < 3; s++) begin
         tick();
         check($sformatf("bp_hold_valid_s%0d", s), bus.out_valid, 1);
         check($sformatf("bp_hold_data_s%0d", s),  bus.out_data,  8'h31);
         check($sformatf("bp_hold_ack0_s%0d", s),  bus.ack0,      0);
         check($sformatf("bp_hold_sel_s%0d", s),   bus.mux_sel,   0);
      end
      bus.out_ready = 1'b1;
      settle();
      check("bp_resume_ack0", bus.ack0, 1);
      tick();
      bus.data0 = 8'h33;
      settle();
      check("bp_data_32", bus.out_data,  8'h32);
      check("bp_valid_32", bus.out_valid, 1);
      check("bp_ack0_b3", bus.ack0,      1);
      tick();
      bus.data0 = 8'h34;
      settle();
      check("bp_data_33", bus.out_data, 8'h33);
      check("bp_ack0_b4", bus.ack0,     1);
      tick();
      bus.data1 = 8'h41;
      settle();
      check("bp_handover_sel",  bus.mux_sel,  1);
      check("bp_handover_ack1", bus.ack1,     1);
      check("bp_handover_ack0", bus.ack0,     0);
      check("bp_data_34",       bus.out_data, 8'h34);

      // req1 drops after two beats while req0 waits: grant moves to req0
      tick();
      bus.data1 = 8'h42;
      settle();
      check("drop_ack1_b2", bus.ack1,     1);
      check("drop_data_41", bus.out_data, 8'h41);
      tick();
      bus.req1 = 1'b0;
      settle();
      check("drop_ack1_low", bus.ack1,     0);
      check("drop_data_42",  bus.out_data, 8'h42);
      tick();
      bus.data0 = 8'h35;
      settle();
      check("drop_mux_sel", bus.mux_sel, 0);
      check("drop_ack0",    bus.ack0,    1);

      // Reset mid-burst clears everything immediately
      tick();
      check("midrst_pre_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      settle();
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_mux_sel",   bus.mux_sel,   0);
      check("midrst_ack0",      bus.ack0,      0);
      check("midrst_ack1",      bus.ack1,      0);
      check("midrst_out_data",  bus.out_data,  8'h00);
      bus.req0 = 1'b0;
      tick();
      rst_n = 1'b1;

      // MAX_BURST=1: strict alternation under a sustained tie
      bus_b1.req0 = 1'b1; bus_b1.req1 = 1'b1; bus_b1.out_ready = 1'b1;
      bus_b1.data0 = 8'hC0; bus_b1.data1 = 8'hD0;
      tick();
      for (int c = 0; c < 4; c++) begin
         settle();
         g1 = c[0];
         check($sformatf("b1_ack0_c%0d", c),    bus_b1.ack0,    !g1);
         check($sformatf("b1_ack1_c%0d", c),    bus_b1.ack1,    g1);
         check($sformatf("b1_mux_sel_c%0d", c), bus_b1.mux_sel, g1);
         tick();
         check($sformatf("b1_data_c%0d", c), bus_b1.out_data, g1 ? 8'hD0 : 8'hC0);
      end
      bus_b1.req0 = 1'b0; bus_b1.req1 = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mux_select_arbiter
